// File: rtl/lfsr_prbs_checker_pkg.sv
// Shared definitions for the PRBS generator/checker pair: default polynomial
// and the checker state encoding.
package lfsr_prbs_checker_pkg;

   // Default LFSR length and feedback taps (x^8 + x^6 + x^5 + x^4 + 1).
   localparam int unsigned PrbsWidth = 8;
   localparam logic [PrbsWidth-1:0] PrbsTaps = 8'b1011_1000;

   // Checker synchronisation states.
   typedef enum logic [1:0] {
      StSearch = 2'd0,
      StVerify = 2'd1,
      StLocked = 2'd2
   } chk_state_e;

endpackage

// File: rtl/lfsr_prbs_checker_if.sv
// Status/data bundle between a PRBS source and the checker.
interface lfsr_prbs_checker_if #(
   parameter int unsigned CNT_W = 16
);

   logic             bit_in;
   logic             bit_valid;
   logic             clear;
   logic             locked;
   logic             err_pulse;
   logic [CNT_W-1:0] err_cnt;
   logic [CNT_W-1:0] bit_cnt;

   // Source side: drives the bit stream and clear, watches status.
   modport master (
      output bit_in, bit_valid, clear,
      input  locked, err_pulse, err_cnt, bit_cnt
   );

   // Checker side.
   modport slave (
      input  bit_in, bit_valid, clear,
      output locked, err_pulse, err_cnt, bit_cnt
   );

endinterface

// File: rtl/lfsr_prbs_checker_lfsr_predict.sv
// Next-bit prediction of a Fibonacci LFSR: XOR of the register bits selected
// by the tap mask. Shared with the pattern generator.
module lfsr_predict #(
   parameter int unsigned       WIDTH = 8,
   parameter logic [WIDTH-1:0]  TAPS  = 8'b1011_1000
) (
   input  logic [WIDTH-1:0] s,
   output logic             pred
);

   assign pred = ^(s & TAPS);

endmodule

// File: rtl/lfsr_prbs_checker.sv
// Receive-side PRBS checker: self-synchronises a local LFSR to the incoming
// stream, declares lock, then counts bit errors against a free-running replica.
module lfsr_prbs_checker
   import lfsr_prbs_checker_pkg::*;
#(
   parameter int unsigned      WIDTH       = PrbsWidth,
   parameter logic [WIDTH-1:0] TAPS        = PrbsTaps,
   parameter int unsigned      LOCK_THRESH = 16,
   parameter int unsigned      LOSS_THRESH = 4,
   parameter int unsigned      CNT_W       = 16
) (
   input logic                 clk_50m,
   input logic                 rst,
   lfsr_prbs_checker_if.slave  bus
);

   localparam int unsigned FILL_W  = $clog2(WIDTH + 1);
   localparam int unsigned MATCH_W = $clog2(LOCK_THRESH + 1);
   localparam int unsigned RUN_W   = $clog2(LOSS_THRESH + 1);

   localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(WIDTH - 1);
   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_THRESH - 1);
   localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(LOSS_THRESH - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

   chk_state_e         state_q;
   logic [WIDTH-1:0]   s_q;
   logic [FILL_W-1:0]  fill_cnt_q;
   logic [MATCH_W-1:0] match_cnt_q;
   logic [RUN_W-1:0]   err_run_q;
   logic               locked_q;
   logic               err_pulse_q;
   logic [CNT_W-1:0]   err_cnt_q;
   logic [CNT_W-1:0]   bit_cnt_q;

   logic pred;
   logic bit_err;
   logic match;

   lfsr_predict #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
   ) u_predict (
      .s    (s_q),
      .pred (pred)
   );

   assign bit_err = bus.bit_in ^ pred;
   // An all-zero register predicts zero forever; never let it count as a match.
   assign match   = !bit_err && (s_q != '0);

   // Sync FSM, counters and registered status outputs.
   always_ff @(posedge clk_50m) begin
      if (rst) begin
         state_q     <= StSearch;
         s_q         <= '0;
         fill_cnt_q  <= '0;
         match_cnt_q <= '0;
         err_run_q   <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         err_cnt_q   <= '0;
         bit_cnt_q   <= '0;
      end else begin
         err_pulse_q <= 1'b0;

         if (bus.clear) begin
            err_cnt_q <= '0;
            bit_cnt_q <= '0;
         end

         if (bus.bit_valid) begin
            unique case (state_q)
               StSearch: begin
                  s_q <= {s_q[WIDTH-2:0], bus.bit_in};
                  if (fill_cnt_q == FILL_LAST) begin
                     state_q     <= StVerify;
                     fill_cnt_q  <= '0;
                     match_cnt_q <= '0;
                  end else begin
                     fill_cnt_q <= fill_cnt_q + 1'b1;
                  end
               end

               StVerify: begin
                  // Keep loading received bits so a bad fill self-corrects.
                  s_q <= {s_q[WIDTH-2:0], bus.bit_in};
                  if (match) begin
                     if (match_cnt_q == MATCH_LAST) begin
                        state_q     <= StLocked;
                        locked_q    <= 1'b1;
                        match_cnt_q <= '0;
                        err_run_q   <= '0;
                     end else begin
                        match_cnt_q <= match_cnt_q + 1'b1;
                     end
                  end else begin
                     match_cnt_q <= '0;
                  end
               end

               StLocked: begin
                  // Free-running replica: a channel error never enters s.
                  s_q <= {s_q[WIDTH-2:0], pred};
                  if (!bus.clear && (bit_cnt_q != CNT_MAX)) begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
                  if (bit_err) begin
                     err_pulse_q <= 1'b1;
                     if (!bus.clear && (err_cnt_q != CNT_MAX)) begin
                        err_cnt_q <= err_cnt_q + 1'b1;
                     end
                     if (err_run_q == RUN_LAST) begin
                        state_q    <= StSearch;
                        fill_cnt_q <= '0;
                        err_run_q  <= '0;
                        locked_q   <= 1'b0;
                     end else begin
                        err_run_q <= err_run_q + 1'b1;
                     end
                  end else begin
                     err_run_q <= '0;
                  end
               end

               default: begin
                  state_q    <= StSearch;
                  fill_cnt_q <= '0;
                  locked_q   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.locked    = locked_q;
   assign bus.err_pulse = err_pulse_q;
   assign bus.err_cnt   = err_cnt_q;
   assign bus.bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Self-checking bench for lfsr_prbs_checker: a behavioural reference model
// feeds a scoreboard queue, plus milestone checks on lock timing and counts.
module tb_lfsr_prbs_checker;
   import lfsr_prbs_checker_pkg::*;

   localparam logic [7:0] TapsV = PrbsTaps;

   typedef struct packed {
      logic        locked;
      logic        pulse;
      logic [15:0] err;
      logic [15:0] bits;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lfsr_prbs_checker_if #(.CNT_W(16)) bus ();

   lfsr_prbs_checker #(
      .WIDTH       (8),
      .TAPS        (PrbsTaps),
      .LOCK_THRESH (16),
      .LOSS_THRESH (4),
      .CNT_W       (16)
   ) dut (
      .clk_50m (clk),
      .rst     (rst),
      .bus     (bus)
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];

   // Reference model state.
   int         m_mode;    // 0 search, 1 verify, 2 locked
   logic [7:0] m_reg;
   int         m_fill, m_match, m_run, m_err, m_bits;
   logic       m_locked, m_pulse;

   // Pattern generator state.
   logic [7:0] gen_s;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic gen_bit(output logic b);
      b = gen_s[7] ^ gen_s[5] ^ gen_s[4] ^ gen_s[3];
      gen_s = {gen_s[6:0], b};
   endtask

   task automatic model(input logic r, input logic v, input logic b, input logic clr);
      logic p;
      logic ok;
      if (r) begin
         m_mode = 0; m_reg = '0; m_fill = 0; m_match = 0; m_run = 0;
         m_err = 0; m_bits = 0; m_locked = 1'b0; m_pulse = 1'b0;
         return;
      end
      m_pulse = 1'b0;
      p = 1'b0;
      for (int i = 0; i < 8; i++) if (TapsV[i]) p ^= m_reg[i];
      if (clr) begin
         m_err = 0;
         m_bits = 0;
      end
      if (!v) return;
      case (m_mode)
         0: begin
            m_reg = {m_reg[6:0], b};
            m_fill++;
            if (m_fill == 8) begin
               m_mode = 1; m_fill = 0; m_match = 0;
            end
         end
         1: begin
            ok = (b == p) && (m_reg != 8'h00);
            m_reg = {m_reg[6:0], b};
            m_match = ok ? m_match + 1 : 0;
            if (m_match == 16) begin
               m_mode = 2; m_locked = 1'b1; m_match = 0; m_run = 0;
            end
         end
         default: begin
            m_reg = {m_reg[6:0], p};
            if (!clr && m_bits < 65535) m_bits++;
            if (b != p) begin
               m_pulse = 1'b1;
               if (!clr && m_err < 65535) m_err++;
               m_run++;
               if (m_run == 4) begin
                  m_mode = 0; m_fill = 0; m_run = 0; m_locked = 1'b0;
               end
            end else begin
               m_run = 0;
            end
         end
      endcase
   endtask

   // One clock: drive inputs, predict, then compare just after the edge.
   task automatic step(input logic v, input logic b, input logic clr, input logic r);
      exp_t e;
      exp_t o;
      rst = r;
      bus.bit_valid = v;
      bus.bit_in = b;
      bus.clear = clr;
      model(r, v, b, clr);
      e.locked = m_locked;
      e.pulse  = m_pulse;
      e.err    = 16'(m_err);
      e.bits   = 16'(m_bits);
      sb.push_back(e);
      @(posedge clk);
      #1;
      o = sb.pop_front();
      check_eq("sb_locked", 32'(bus.locked), 32'(o.locked));
      check_eq("sb_err_pulse", 32'(bus.err_pulse), 32'(o.pulse));
      check_eq("sb_err_cnt", 32'(bus.err_cnt), 32'(o.err));
      check_eq("sb_bit_cnt", 32'(bus.bit_cnt), 32'(o.bits));
   endtask

   // Clean stream until lock; returns the valid-bit index at which locked rose.
   task automatic run_to_lock(input int budget, output int lock_at);
      logic b;
      lock_at = 0;
      for (int i = 1; i <= budget; i++) begin
         gen_bit(b);
         step(1'b1, b, 1'b0, 1'b0);
         if (lock_at == 0 && bus.locked) lock_at = i;
      end
   endtask

   task automatic do_reset(input logic [7:0] seed);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      gen_s = seed;
   endtask

   initial begin
      logic b;
      int   lock_at;
      int   lock_cyc;
      int   seen;

      bus.bit_valid = 1'b0;
      bus.bit_in    = 1'b0;
      bus.clear     = 1'b0;
      model(1'b1, 1'b0, 1'b0, 1'b0);

      // Reset state.
      do_reset(8'h01);
      check_eq("rst_locked", 32'(bus.locked), 32'd0);
      check_eq("rst_err_pulse", 32'(bus.err_pulse), 32'd0);
      check_eq("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
      check_eq("rst_bit_cnt", 32'(bus.bit_cnt), 32'd0);

      // Continuous stream: lock after 8 fill + 16 matches.
      run_to_lock(40, lock_at);
      check_eq("lock_at_first", 32'(lock_at), 32'd24);
      check_eq("bit_cnt_40", 32'(bus.bit_cnt), 32'd16);
      check_eq("err_cnt_clean", 32'(bus.err_cnt), 32'd0);

      // Single inverted bit.
      gen_bit(b);
      step(1'b1, ~b, 1'b0, 1'b0);
      check_eq("single_pulse", 32'(bus.err_pulse), 32'd1);
      check_eq("single_err_cnt", 32'(bus.err_cnt), 32'd1);
      gen_bit(b);
      step(1'b1, b, 1'b0, 1'b0);
      check_eq("single_pulse_gone", 32'(bus.err_pulse), 32'd0);
      run_to_lock(20, lock_at);
      check_eq("single_no_followon", 32'(bus.err_cnt), 32'd1);
      check_eq("single_still_locked", 32'(bus.locked), 32'd1);

      // Clear, then four consecutive errors drop lock.
      gen_bit(b);
      step(1'b1, b, 1'b1, 1'b0);
      check_eq("clear_err_cnt", 32'(bus.err_cnt), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         gen_bit(b);
         step(1'b1, ~b, 1'b0, 1'b0);
         if (k == 3) check_eq("burst3_locked", 32'(bus.locked), 32'd1);
      end
      check_eq("burst4_locked", 32'(bus.locked), 32'd0);
      check_eq("burst4_err_cnt", 32'(bus.err_cnt), 32'd4);
      run_to_lock(40, lock_at);
      check_eq("relock_at", 32'(lock_at), 32'd24);

      // Lose lock again, reset while verifying, then relock from scratch.
      for (int k = 1; k <= 4; k++) begin
         gen_bit(b);
         step(1'b1, ~b, 1'b0, 1'b0);
      end
      for (int k = 0; k < 10; k++) begin
         gen_bit(b);
         step(1'b1, b, 1'b0, 1'b0);
      end
      check_eq("pre_rst_err_cnt", 32'(bus.err_cnt), 32'd8);
      gen_bit(b);
      step(1'b1, b, 1'b0, 1'b1);
      check_eq("verify_rst_err_cnt", 32'(bus.err_cnt), 32'd0);
      check_eq("verify_rst_bit_cnt", 32'(bus.bit_cnt), 32'd0);
      check_eq("verify_rst_locked", 32'(bus.locked), 32'd0);
      run_to_lock(40, lock_at);
      check_eq("post_rst_lock_at", 32'(lock_at), 32'd24);

      // All-zero stream never locks.
      do_reset(8'h01);
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         if (bus.locked) seen++;
      end
      check_eq("zero_never_locked", 32'(seen), 32'd0);
      check_eq("zero_err_cnt", 32'(bus.err_cnt), 32'd0);

      // Alternating bit_valid with junk on idle cycles.
      do_reset(8'h01);
      lock_cyc = 0;
      for (int c = 1; c <= 100; c++) begin
         if (c % 2 == 1) begin
            gen_bit(b);
            step(1'b1, b, 1'b0, 1'b0);
         end else begin
            step(1'b0, 1'($urandom_range(1)), 1'b0, 1'b0);
            check_eq("idle_no_pulse", 32'(bus.err_pulse), 32'd0);
         end
         if (lock_cyc == 0 && bus.locked) lock_cyc = c;
      end
      check_eq("alt_lock_cycle", 32'(lock_cyc), 32'd47);
      check_eq("alt_bit_cnt", 32'(bus.bit_cnt), 32'd26);

      // Clear coincident with an errored bit.
      gen_bit(b);
      step(1'b1, ~b, 1'b0, 1'b0);
      check_eq("pre_clear_err_cnt", 32'(bus.err_cnt), 32'd1);
      gen_bit(b);
      step(1'b1, b, 1'b0, 1'b0);
      gen_bit(b);
      step(1'b1, ~b, 1'b1, 1'b0);
      check_eq("clear_err_wins", 32'(bus.err_cnt), 32'd0);
      check_eq("clear_err_pulse", 32'(bus.err_pulse), 32'd1);
      check_eq("clear_keeps_lock", 32'(bus.locked), 32'd1);
      check_eq("clear_bit_cnt", 32'(bus.bit_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lfsr_prbs_checker.md
Name: lfsr_prbs_checker

Overview:
- Receive-side counterpart of the Fibonacci LFSR pattern generator.
- Takes the serial PRBS bit stream, self-synchronises its local LFSR to it, and declares lock.
- Once locked, counts bit errors against a free-running local replica.
- err_cnt and locked feed the board's seven-segment/LED status path at top level.

Parameters:
- WIDTH, 8, LFSR length in bits.
- TAPS, 8'b1011_1000, feedback tap mask (bit i set = s[i] in XOR); default is x^8+x^6+x^5+x^4+1.
- LOCK_THRESH, 16, consecutive correct predictions required to lock.
- LOSS_THRESH, 4, consecutive errors while locked that drop lock.
- CNT_W, 16, width of err_cnt and bit_cnt.

Ports:
- clk_50m  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_in  input  1  received PRBS bit.
- bit_valid  input  1  bit_in is sampled only when high.
- clear  input  1  synchronous clear of err_cnt and bit_cnt only.
- locked  output  1  checker is synchronised.
- err_pulse  output  1  one-cycle pulse per errored bit while locked.
- err_cnt  output  CNT_W  saturating count of errored bits while locked.
- bit_cnt  output  CNT_W  saturating count of bits checked while locked.

Behaviour:
- Reset:
  - state=SEARCH; shift register s, fill_cnt, match_cnt, err_run = 0.
  - locked=0, err_pulse=0, err_cnt=0, bit_cnt=0.
- Prediction: pred = XOR of s[i] over TAPS (from s before the shift). Shift is s <= {s[WIDTH-2:0], x}.
- Cycles with bit_valid=0 change no state. err_pulse is 0 in those cycles.
- SEARCH:
  - Each valid bit: s <= {s, bit_in}; fill_cnt++.
  - On the WIDTH-th valid bit: go to VERIFY, match_cnt=0.
- VERIFY:
  - Each valid bit: shift bit_in into s (self-sync).
  - Match = (bit_in==pred) and s!=0 (zero-state guard: an all-zero register never counts as a match).
  - Match: match_cnt++. Mismatch: match_cnt<=0 and stay in VERIFY.
  - When match_cnt reaches LOCK_THRESH: go to LOCKED. locked=1 from the cycle after that valid bit.
- LOCKED:
  - s shifts in pred (free-running replica), so each channel error is counted exactly once.
  - bit_cnt++ per valid bit.
  - If bit_in!=pred: err_pulse=1 next cycle, err_cnt++, err_run++. Otherwise err_run<=0.
  - When err_run reaches LOSS_THRESH, the errored bit is still counted. Then state=SEARCH, fill_cnt=0, and locked=0 from the next cycle.
- All outputs are registered, with latency 1 cycle from the sampling edge.
- Counters saturate at all-ones and never wrap.
- clear:
  - Zeroes err_cnt and bit_cnt next cycle and wins over a simultaneous increment.
  - err_pulse still fires; state and lock are unaffected.
- rst mid-operation: immediate return to the reset values above on the next edge, regardless of state.

Decomposition:
- Shared header holds the checker state encoding and the default WIDTH/TAPS polynomial constant, also used by the generator so both ends agree.
- Sub-module lfsr_predict: combinational tap-mask XOR (s, TAPS -> pred), reused by the generator.

Test Plan:
- Reset, then a continuous generator stream seeded 8'h01 with bit_valid=1 → locked rises the cycle after the 24th valid bit (8 fill + 16 matches); err_cnt=0 and bit_cnt counts from the 25th bit.
- Locked, invert one bit → err_pulse high exactly one cycle; err_cnt=1; locked stays 1; no follow-on errors.
- Locked, invert 4 consecutive bits → err_cnt=4; locked falls the cycle after the 4th; clean stream relocks after a further 24 valid bits.
- All-zero input stream for 100 valid bits → locked never asserts; err_cnt=0.
- Same stream with bit_valid alternating 1/0 → lock after the 24th valid bit (~48 cycles); no change on invalid cycles.
- Assert clear together with an errored bit while locked → err_cnt=0 next cycle and err_pulse=1. rst during VERIFY → all outputs 0 next cycle.
